plasma_mem_arbiter: RTL and testbench

Two-master arbiter for the Plasma external memory bus. It shares one external memory port between the Plasma CPU (address/byte_we/data_write/data_read/mem_pause_in) and a DMA requester using round-robin arbitration. It stalls the CPU through mem_pause while its external access is pending, and aborts hung accesses with a timeout. It sits between the plasma core instance and the board-level memory/peripheral controller.

---
 rtl/plasma_mem_arbiter_if.sv | 19 +
 rtl/plasma_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_plasma_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plasma_mem_arbiter_if.sv
// External memory bus between the arbiter and the board-level memory controller.
interface plasma_mem_arbiter_if;
  logic        mem_req;
  logic [3:0]  mem_byte_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_byte_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_byte_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/plasma_mem_arbiter.sv
// Two-master round-robin arbiter (Plasma CPU + DMA) for one external memory port,
// with CPU stall generation and a per-access timeout.
module plasma_mem_arbiter #(
  parameter logic [3:0]  EXT_REGION = 4'h1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [31:0]                 cpu_address,
  input  logic [3:0]                  cpu_byte_we,
  input  logic [31:0]                 cpu_data_write,
  output logic [31:0]                 cpu_data_read,
  output logic                        cpu_mem_pause,
  input  logic                        dma_req,
  input  logic [3:0]                  dma_byte_we,
  input  logic [31:0]                 dma_addr,
  input  logic [31:0]                 dma_wdata,
  output logic                        dma_ack,
  output logic [31:0]                 dma_rdata,
  plasma_mem_arbiter_if.master        mem,
  output logic                        err_timeout,
  input  logic                        err_clr,
  output logic [1:0]                  grant
);

  typedef enum logic [2:0] {
    StIdle,
    StCpuWait,
    StCpuDone,
    StDmaWait,
    StDmaDone
  } state_e;

  // Last counter value before the access is abandoned.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_dma_q, last_dma_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] cpu_rd_q, cpu_rd_d;
  logic [31:0] dma_rd_q, dma_rd_d;
  logic        err_q, err_d;
  logic        cpu_hit;
  logic        finish;
  logic [31:0] rdata_fin;

  // Word-aligned addressing: the byte-offset bits never reach the bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_address[1:0];

  assign cpu_hit   = (cpu_address[31:28] == EXT_REGION);
  assign finish    = mem.mem_ready || (cnt_q == TimeoutLast);
  // A hung access returns all ones instead of bus data.
  assign rdata_fin = mem.mem_ready ? mem.mem_rdata : 32'hFFFF_FFFF;

  // Next-state: arbitration in idle, completion/timeout handling in the wait states.
  always_comb begin
    state_d    = state_q;
    last_dma_d = last_dma_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cpu_rd_d   = cpu_rd_q;
    dma_rd_d   = dma_rd_q;
    err_d      = err_q & ~err_clr;

    unique case (state_q)
      StIdle: begin
        // On a tie the master that was not served last wins.
        if (cpu_hit && (!dma_req || last_dma_q)) begin
          state_d    = StCpuWait;
          last_dma_d = 1'b0;
          cnt_d      = '0;
          req_d      = 1'b1;
          we_d       = cpu_byte_we;
          addr_d     = {cpu_address[31:2], 2'b00};
          wdata_d    = cpu_data_write;
        end else if (dma_req) begin
          state_d    = StDmaWait;
          last_dma_d = 1'b1;
          cnt_d      = '0;
          req_d      = 1'b1;
          we_d       = dma_byte_we;
          addr_d     = dma_addr;
          wdata_d    = dma_wdata;
        end
      end
      StCpuWait, StDmaWait: begin
        if (finish) begin
          req_d = 1'b0;
          if (!mem.mem_ready) err_d = 1'b1;
          if (state_q == StCpuWait) begin
            cpu_rd_d = rdata_fin;
            state_d  = StCpuDone;
          end else begin
            dma_rd_d = rdata_fin;
            state_d  = StDmaDone;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StCpuDone, StDmaDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      last_dma_q <= 1'b1;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_rd_q   <= '0;
      dma_rd_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dma_q <= last_dma_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_rd_q   <= cpu_rd_d;
      dma_rd_q   <= dma_rd_d;
      err_q      <= err_d;
    end
  end

  // Outputs decoded from state; pause is forced low while in reset.
  always_comb begin
    cpu_mem_pause = cpu_hit & (state_q != StCpuDone) & reset_n;
    dma_ack       = (state_q == StDmaDone);
    grant         = 2'b00;
    grant[0]      = (state_q == StCpuWait) || (state_q == StCpuDone);
    grant[1]      = (state_q == StDmaWait) || (state_q == StDmaDone);
  end

  assign mem.mem_req     = req_q;
  assign mem.mem_byte_we = we_q;
  assign mem.mem_addr    = addr_q;
  assign mem.mem_wdata   = wdata_q;
  assign cpu_data_read   = cpu_rd_q;
  assign dma_rdata       = dma_rd_q;
  assign err_timeout     = err_q;

endmodule

// File: tb/tb_plasma_mem_arbiter.sv
// Bench for plasma_mem_arbiter: directed scenarios, a transaction-level model
// checked every cycle, and literal expectations per scenario.
module tb_plasma_mem_arbiter;
  localparam int unsigned TO = 8;
  localparam int NONE = 0;
  localparam int CPU  = 1;
  localparam int DMA  = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] cpu_address = '0;
  logic [3:0]  cpu_byte_we = '0;
  logic [31:0] cpu_data_write = '0;
  logic [31:0] cpu_data_read;
  logic        cpu_mem_pause;
  logic        dma_req = 1'b0;
  logic [3:0]  dma_byte_we = '0;
  logic [31:0] dma_addr = '0;
  logic [31:0] dma_wdata = '0;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic        err_timeout;
  logic        err_clr = 1'b0;
  logic [1:0]  grant;

  plasma_mem_arbiter_if mem ();

  plasma_mem_arbiter #(.EXT_REGION(4'h1), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_address(cpu_address), .cpu_byte_we(cpu_byte_we), .cpu_data_write(cpu_data_write),
    .cpu_data_read(cpu_data_read), .cpu_mem_pause(cpu_mem_pause),
    .dma_req(dma_req), .dma_byte_we(dma_byte_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem(mem),
    .err_timeout(err_timeout), .err_clr(err_clr), .grant(grant)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Stimulus knobs read by the responders.
  int          lat = 0;           // WAIT cycles before mem_ready; negative = never
  logic [31:0] rdata_val = '0;
  int          dma_left = 0;      // DMA transfers still to issue
  int          acks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          m_owner, m_done, m_age;
  bit          m_last_cpu, m_err;
  logic [31:0] m_addr, m_wdata, m_cpu_rd, m_dma_rd;
  logic [3:0]  m_we;

  task automatic model_reset();
    m_owner = NONE; m_done = NONE; m_age = 0; m_last_cpu = 1'b0; m_err = 1'b0;
    m_addr = '0; m_wdata = '0; m_we = '0; m_cpu_rd = '0; m_dma_rd = '0;
  endtask

  task automatic model_step();
    bit          hit;
    logic [31:0] rd;
    hit = (cpu_address[31:28] == 4'h1);
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (err_clr) m_err = 1'b0;
    if (m_done != NONE) begin
      m_done = NONE;
    end else if (m_owner != NONE) begin
      m_age++;
      if (mem.mem_ready || m_age == int'(TO)) begin
        rd = mem.mem_ready ? mem.mem_rdata : 32'hFFFF_FFFF;
        if (!mem.mem_ready) m_err = 1'b1;
        if (m_owner == CPU) m_cpu_rd = rd;
        else m_dma_rd = rd;
        m_done  = m_owner;
        m_owner = NONE;
      end
    end else if (hit && (!dma_req || !m_last_cpu)) begin
      m_owner = CPU; m_last_cpu = 1'b1; m_age = 0;
      m_addr = {cpu_address[31:2], 2'b00}; m_we = cpu_byte_we; m_wdata = cpu_data_write;
    end else if (dma_req) begin
      m_owner = DMA; m_last_cpu = 1'b0; m_age = 0;
      m_addr = dma_addr; m_we = dma_byte_we; m_wdata = dma_wdata;
    end
  endtask

  // Every-cycle comparison against the model, on the falling edge.
  initial begin
    logic [1:0] g;
    model_reset();
    forever begin
      @(negedge clk);
      if (!reset_n) model_reset();
      g[0] = (m_owner == CPU) || (m_done == CPU);
      g[1] = (m_owner == DMA) || (m_done == DMA);
      chk("mem_req", 32'(mem.mem_req), 32'(m_owner != NONE));
      chk("mem_addr", mem.mem_addr, m_addr);
      chk("mem_byte_we", 32'(mem.mem_byte_we), 32'(m_we));
      chk("mem_wdata", mem.mem_wdata, m_wdata);
      chk("cpu_data_read", cpu_data_read, m_cpu_rd);
      chk("dma_rdata", dma_rdata, m_dma_rd);
      chk("dma_ack", 32'(dma_ack), 32'(m_done == DMA));
      chk("err_timeout", 32'(err_timeout), 32'(m_err));
      chk("grant", 32'(grant), 32'(g));
      chk("cpu_mem_pause", 32'(cpu_mem_pause),
          32'(reset_n && (cpu_address[31:28] == 4'h1) && (m_done != CPU)));
      model_step();
    end
  end

  // Memory and DMA responders, acting 2 time units after each rising edge.
  initial begin
    int hi;
    hi = 0;
    mem.mem_ready = 1'b0;
    mem.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      hi = mem.mem_req ? hi + 1 : 0;
      mem.mem_ready = mem.mem_req && (lat >= 0) && (hi == lat + 1);
      mem.mem_rdata = rdata_val;
      if (dma_ack) begin
        dma_req = 1'b0;
        acks++;
        if (dma_left > 0) dma_left--;
      end else if (dma_left > 0) begin
        dma_req = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int c;
    for (c = 0; c < 60; c++) begin
      @(negedge clk);
      if (grant == 2'b00 && dma_left == 0 && !dma_req && !mem.mem_req) break;
    end
    chk(name, 32'(c < 60), 32'd1);
  endtask

  // Wait for the CPU_DONE cycle, then move the CPU off the external region.
  task automatic cpu_release(input string name);
    int c;
    for (c = 0; c < 60; c++) begin
      @(negedge clk);
      if (grant == 2'b01 && !cpu_mem_pause) break;
    end
    chk(name, 32'(c < 60), 32'd1);
    tick();
    cpu_address = 32'h0000_0000;
    cpu_byte_we = 4'h0;
  endtask

  initial begin
    int          n, pc, wc, hc, a0;
    bit          done;
    logic [1:0]  prev;
    logic [1:0]  seq [3];

    // Reset: pause stays low even with an external address presented.
    cpu_address = 32'h1000_0000;
    repeat (2) @(negedge clk);
    chk("rst_pause", 32'(cpu_mem_pause), 32'd0);
    chk("rst_mem_req", 32'(mem.mem_req), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    tick();
    reset_n = 1'b1;
    cpu_address = 32'h0000_0000;
    tick();

    // Tie after reset: CPU, DMA, CPU.
    lat = 0; rdata_val = 32'h1111_0001;
    dma_addr = 32'h1000_0020; dma_byte_we = 4'h0; dma_wdata = 32'h0;
    dma_left = 2; cpu_address = 32'h1000_0000;
    n = 0; prev = 2'b00;
    foreach (seq[i]) seq[i] = 2'b00;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      if (grant != 2'b00 && grant != prev) begin
        seq[n] = grant;
        n++;
      end
      prev = grant;
    end
    chk("tie_onsets", 32'(n), 32'd3);
    chk("tie_grant0", 32'(seq[0]), 32'd1);
    chk("tie_grant1", 32'(seq[1]), 32'd2);
    chk("tie_grant2", 32'(seq[2]), 32'd1);
    cpu_release("tie_cpu_done");
    wait_idle("tie_idle");
    tick();

    // CPU read, ready in first WAIT cycle.
    rdata_val = 32'hCAFE_F00D;
    cpu_address = 32'h1000_0010;
    pc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!cpu_mem_pause) break;
      pc++;
    end
    chk("rd_pause_cycles", 32'(pc), 32'd2);
    chk("rd_data", cpu_data_read, 32'hCAFE_F00D);
    chk("rd_mem_addr", mem.mem_addr, 32'h1000_0010);
    tick();

    // Non-external CPU address: no bus activity, no stall.
    cpu_address = 32'h0000_0100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("noext_mem_req", 32'(mem.mem_req), 32'd0);
      chk("noext_pause", 32'(cpu_mem_pause), 32'd0);
    end
    tick();

    // DMA write with 5 wait cycles; CPU hit arrives mid-transfer.
    lat = 5; rdata_val = 32'h5555_AAAA;
    dma_addr = 32'h1000_0040; dma_byte_we = 4'b0011; dma_wdata = 32'h1234_5678;
    dma_left = 1;
    a0 = acks; wc = 0; pc = 0; done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (mem.mem_req && mem.mem_byte_we == 4'b0011 && mem.mem_addr == 32'h1000_0040) wc++;
      if (cpu_mem_pause) pc++;
      if (c >= 2 && grant == 2'b01 && !cpu_mem_pause) begin
        done = 1'b1;
        break;
      end
      tick();
      if (c == 1) begin
        cpu_address = 32'h1000_0080; cpu_byte_we = 4'hF; cpu_data_write = 32'hDEAD_BEEF;
      end
    end
    chk("dmaw_done", 32'(done), 32'd1);
    chk("dmaw_we_cycles", 32'(wc), 32'd6);
    chk("dmaw_cpu_pause", 32'(pc), 32'd13);
    chk("dmaw_ack_pulses", 32'(acks - a0), 32'd1);
    tick();
    cpu_address = 32'h0000_0000; cpu_byte_we = 4'h0;
    wait_idle("dmaw_idle");
    tick();

    // Timeout on a CPU read.
    lat = -1;
    cpu_address = 32'h1000_0100;
    hc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem.mem_req) hc++;
      if (c > 0 && !cpu_mem_pause) break;
    end
    chk("to_req_cycles", 32'(hc), 32'd8);
    chk("to_data", cpu_data_read, 32'hFFFF_FFFF);
    chk("to_err_set", 32'(err_timeout), 32'd1);
    tick();
    cpu_address = 32'h0000_0000;
    repeat (3) @(negedge clk);
    chk("to_err_sticky", 32'(err_timeout), 32'd1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    chk("to_err_cleared", 32'(err_timeout), 32'd0);
    tick();

    // Reset during DMA_WAIT.
    dma_addr = 32'h1000_0200; dma_byte_we = 4'h0; dma_left = 1;
    a0 = acks;
    repeat (3) tick();
    chk("rst_mid_req_before", 32'(mem.mem_req), 32'd1);
    reset_n = 1'b0;
    dma_left = 0;
    dma_req = 1'b0;
    #1;
    chk("rst_mid_req_async", 32'(mem.mem_req), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_mid_no_ack", 32'(acks - a0), 32'd0);
    lat = 0; rdata_val = 32'h7777_0007;
    cpu_address = 32'h1000_0000; dma_left = 1;
    n = 0;
    prev = 2'b00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (grant != 2'b00) begin
        prev = grant;
        n = 1;
        break;
      end
    end
    chk("rst_tie_seen", 32'(n), 32'd1);
    chk("rst_tie_cpu_first", 32'(prev), 32'd1);
    cpu_release("rst_cpu_done");
    wait_idle("rst_idle");
    chk("rst_post_acks", 32'(acks - a0), 32'd1);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
